// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    // Most negative two's-complement value for a given width (width <= 64).
    function automatic logic [63:0] min_int(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift in a dividend bit, subtract the divisor if it fits.
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // The partial remainder is always below dmag, so the difference fits in WIDTH bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, dmag});
        rem_out = q_bit ? (shifted[WIDTH-1:0] - dmag) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: sign/magnitude wrapper around a restoring core, start/done handshake.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned      CW      = $clog2(WIDTH);
    localparam logic [63:0]      MIN64   = min_int(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = MIN64[WIDTH-1:0];

    div_state_t       state, state_next;
    logic [WIDTH-1:0] aq;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             neg_q, neg_r, min_neg1;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;

    always_comb begin
        a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    end

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (aq[WIDTH-1]),
        .dmag    (dmag),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    // done is registered one cycle behind the DONE state, so a start seen while done is high is refused.
    assign busy = (state != IDLE) || done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && !done) state_next = (divisor == '0) ? DONE : CALC;
            CALC: if (count == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            aq          <= '0;
            dmag        <= '0;
            rem         <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            min_neg1    <= 1'b0;
        end else if (en) begin
            done <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start && !done) begin
                        aq       <= a_mag;
                        dmag     <= b_mag;
                        rem      <= '0;
                        count    <= CW'(WIDTH - 1);
                        neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r    <= dividend[WIDTH-1];
                        min_neg1 <= (dividend == MIN_VAL) && (divisor == '1);
                        overflow <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    aq    <= {aq[WIDTH-2:0], q_bit};
                    rem   <= rem_step;
                    count <= count - 1'b1;
                end
                FIX: begin
                    quotient  <= neg_q ? (~aq + 1'b1) : aq;
                    remainder <= neg_r ? (~rem + 1'b1) : rem;
                    overflow  <= min_neg1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (WIDTH=32) against a plain-arithmetic reference.
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        reset, en, start;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero, overflow;
    logic [31:0] quotient, remainder;

    int vectors     = 0;
    int miscompares = 0;

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            r  = 32'h0;
            ov = 1'b1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int hold_at, input int hold_len, input bit poke);
        logic [31:0] eq, er;
        logic        edz, eov;
        int          cycles;
        int          exp_lat;
        model(a, b, eq, er, edz, eov);
        exp_lat = (b == 32'h0) ? 1 : 34 + hold_len;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1 && b != 32'h0) check("cleared_quotient", quotient, 32'h0);
            if (poke && cycles == 5) begin
                start    = 1'b1;
                dividend = 32'd100;
                divisor  = 32'd7;
            end
            if (poke && cycles == 6) start = 1'b0;
            if (hold_len > 0 && cycles == hold_at) en = 1'b0;
            if (hold_len > 0 && cycles == hold_at + hold_len) en = 1'b1;
        end
        check("latency", cycles, exp_lat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", 32'(div_by_zero), 32'(edz));
        check("overflow", 32'(overflow), 32'(eov));
        check("busy_at_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_released", 32'(busy), 32'd0);
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;

        reset    = 1'b1;
        en       = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", quotient, 32'h0);
        check("reset_remainder", remainder, 32'h0);
        check("reset_flags", {30'd0, div_by_zero, overflow}, 32'h0);
        reset = 1'b0;

        do_op(-32'sd35, 32'd5, 0, 0, 1'b0);
        do_op(32'd48, -32'sd4, 0, 0, 1'b0);
        do_op(-32'sd45, -32'sd9, 0, 0, 1'b0);
        do_op(32'd7, 32'd2, 0, 0, 1'b0);
        do_op(-32'sd7, 32'd2, 0, 0, 1'b0);
        do_op(32'd7, -32'sd2, 0, 0, 1'b0);
        do_op(32'd11, 32'd0, 0, 0, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        do_op(32'h8000_0000, 32'd1, 0, 0, 1'b0);
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 1'b0);
        do_op(32'd10, 32'd3, 0, 0, 1'b1);
        do_op(32'd10, 32'd3, 10, 8, 1'b0);

        // en low while done is high: done must stretch, then drop after one enabled cycle
        @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("dz_done", 32'(done), 32'd1);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_held_en0", 32'(done), 32'd1);
        check("result_held_en0", remainder, 32'd9);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("done_drop_after_en", 32'(done), 32'd0);

        // reset in the middle of a computation aborts it
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", quotient, 32'h0);
        check("abort_remainder", remainder, 32'h0);
        check("abort_flags", {30'd0, div_by_zero, overflow}, 32'h0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        do_op(32'd24, 32'd6, 0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) rb = 32'($signed($urandom_range(0, 20)) - 10);
            else rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
            do_op(ra, rb, 0, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
